// File: rtl/jt49_player_pkg.sv
// jt49_player_pkg
// Shared definitions for the jt49 command player: the 2-bit opcodes found
// in cmd_data[9:8] and the sequencer state encoding.
package jt49_player_pkg;

    localparam logic [1:0] OP_WR   = 2'b00;  // data write
    localparam logic [1:0] OP_ADR  = 2'b01;  // address latch
    localparam logic [1:0] OP_WAIT = 2'b10;  // timed wait
    localparam logic [1:0] OP_END  = 2'b11;  // end of playback

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        BUS,
        GAP,
        WAIT,
        NEXT,
        FIN
    } state_t;

endpackage

// File: rtl/jt49_player_timer.sv
// jt49_player_timer
// Loadable down-counter with a tick enable and a zero flag. The counter
// stops at zero, so a loaded value N reports zero after N ticks.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load load_val (takes priority over tick)
//   load_val    - value to load
//   tick        - decrement enable
//   zero        - count is zero
module jt49_player_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/jt49_cmd_player.sv
// jt49_cmd_player
// Register-write sequencer for jt49_bus. Fetches 10-bit commands from a
// synchronous ROM (data valid one clk after cmd_addr changes) and drives
// bdir/bc1/din: address latch, data write, timed wait and end.
// Optional feature: define JT49_PLAYER_LOOP_EN to make an end command
// pulse done and restart at the latched start address instead of stopping.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cen         - clock enable, used only as the wait-counter tick
//   start       - begin playback at start_addr (sampled in IDLE only)
//   stop        - request early termination
//   start_addr  - first command address
//   cmd_addr    - ROM address
//   cmd_data    - ROM data
//   bdir, bc1   - bus control to jt49_bus
//   dout        - bus data to jt49_bus din
//   busy        - high whenever the sequencer is not IDLE
//   done        - one-clk pulse on completion or stop
module jt49_cmd_player
    import jt49_player_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int BUS_CYC = 8,
    parameter int GAP_CYC = 2,
    parameter int WAIT_SH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic [9:0]        cmd_data,
    output logic              bdir,
    output logic              bc1,
    output logic [7:0]        dout,
    output logic              busy,
    output logic              done
);

    // Wide enough for the largest wait (255 << WAIT_SH) without overflow.
    localparam int TW = 8 + WAIT_SH;

    state_t        state;
    logic          stop_pend;   // stop seen during BUS, honoured after GAP
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_tick;
    logic          tmr_zero;
`ifdef JT49_PLAYER_LOOP_EN
    logic [ADDR_W-1:0] start_lat;
    logic              loop_again;  // FIN was reached through an end command
`endif

    // Timer loads are issued on the cycle that enters BUS, GAP or WAIT.
    // Values are N-1 for BUS/GAP because the exit cycle itself counts.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            EXEC: begin
                if (!stop && !cmd_data[9]) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(BUS_CYC - 1);
                end else if (!stop && (cmd_data[9:8] == OP_WAIT)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(cmd_data[7:0]) << WAIT_SH;
                end
            end
            BUS: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYC - 1);
                end
            end
            default: ;
        endcase
    end

    assign tmr_tick = (state == WAIT) ? cen : 1'b1;

    jt49_player_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .zero     (tmr_zero)
    );

    // done is raised together with every transition into FIN so that it
    // is high exactly during the FIN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_addr  <= '0;
            bdir      <= 1'b0;
            bc1       <= 1'b0;
            dout      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stop_pend <= 1'b0;
`ifdef JT49_PLAYER_LOOP_EN
            start_lat  <= '0;
            loop_again <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_addr  <= start_addr;
                        busy      <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= FETCH;
`ifdef JT49_PLAYER_LOOP_EN
                        start_lat <= start_addr;
`endif
                    end
                end
                FETCH: begin
                    if (stop) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (stop) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        case (cmd_data[9:8])
                            OP_WR, OP_ADR: begin
                                bdir  <= 1'b1;
                                bc1   <= cmd_data[8];
                                dout  <= cmd_data[7:0];
                                state <= BUS;
                            end
                            OP_WAIT: begin
                                state <= (cmd_data[7:0] != 8'd0) ? WAIT : NEXT;
                            end
                            default: begin
                                state <= FIN;
                                done  <= 1'b1;
`ifdef JT49_PLAYER_LOOP_EN
                                loop_again <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                BUS: begin
                    if (stop) stop_pend <= 1'b1;
                    if (tmr_zero) begin
                        bdir  <= 1'b0;
                        bc1   <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (stop || (tmr_zero && stop_pend)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (tmr_zero) begin
                        state <= NEXT;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else if (tmr_zero) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    // No wrap: the last ROM address terminates playback.
                    if (stop || (&cmd_addr)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        cmd_addr <= cmd_addr + 1'b1;
                        state    <= FETCH;
                    end
                end
                FIN: begin
                    stop_pend <= 1'b0;
`ifdef JT49_PLAYER_LOOP_EN
                    loop_again <= 1'b0;
                    if (loop_again && !stop) begin
                        cmd_addr <= start_lat;
                        state    <= FETCH;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt49_cmd_player.sv
// tb_jt49_cmd_player
// Directed bench for jt49_cmd_player. Each scenario pushes the bus
// operations and done pulses it expects into exp_q; a monitor sampling on
// the falling clock edge turns observed bus operations and done pulses into
// events and compares them against the queue head.
// Event fields: kind, bc1, dout, high length, cmd_addr, and rel = the edge
// number (start sampled at edge 0) at which the value is first seen.
module tb_jt49_cmd_player;

    localparam int EV_W = 46;
    localparam logic [1:0] K_BUS  = 2'b01;
    localparam logic [1:0] K_DONE = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic        start;
    logic        stop;
    logic [11:0] start_addr;
    logic [11:0] cmd_addr;
    logic [9:0]  cmd_data;
    logic        bdir;
    logic        bc1;
    logic [7:0]  dout;
    logic        busy;
    logic        done;

    logic [9:0]  rom [0:4095];
    logic [EV_W-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    logic cen_run = 1'b0;

    jt49_cmd_player dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .bdir       (bdir),
        .bc1        (bc1),
        .dout       (dout),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- clock / reset / ROM ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) cmd_data <= rom[cmd_addr];

    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cen_run) cen = ~cen;
            else cen = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [EV_W-1:0] ev(input logic [1:0] k, input logic b,
                                           input logic [7:0] d, input logic [7:0] len,
                                           input logic [11:0] a, input logic [11:0] rel,
                                           input logic [2:0] tol);
        return {tol, k, b, d, len, a, rel};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_ev(input logic [EV_W-1:0] got);
        logic [EV_W-1:0] e;
        int diff;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d bc1=%0d dout=%h len=%0d addr=%h rel=%0d",
                     got[42:41], got[40], got[39:32], got[31:24], got[23:12], got[11:0]);
            return;
        end
        e = exp_q.pop_front();
        diff = int'(got[11:0]) - int'(e[11:0]);
        if (diff < 0) diff = -diff;
        if ((got[42:12] !== e[42:12]) || (diff > int'(e[45:43]))) begin
            bad++;
            $display("FAIL event got kind=%0d bc1=%0d dout=%h len=%0d addr=%h rel=%0d exp kind=%0d bc1=%0d dout=%h len=%0d addr=%h rel=%0d",
                     got[42:41], got[40], got[39:32], got[31:24], got[23:12], got[11:0],
                     e[42:41], e[40], e[39:32], e[31:24], e[23:12], e[11:0]);
        end
    endtask

    // ---------------- monitor ----------------
    logic        in_bus = 1'b0;
    logic [7:0]  hi_len;
    logic        m_bc1;
    logic [7:0]  m_dout;
    logic [11:0] m_addr;
    logic [11:0] m_rel;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_bus = 1'b0;
        end else begin
            if (bc1) begin
                total++;
                if (!bdir) begin
                    bad++;
                    $display("FAIL bc1_without_bdir got bdir=0 exp bdir=1");
                end
            end
            if (bdir && !in_bus) begin
                in_bus = 1'b1;
                hi_len = 8'd1;
                m_bc1  = bc1;
                m_dout = dout;
                m_addr = cmd_addr;
                m_rel  = 12'(cyc - t0 + 1);
            end else if (bdir) begin
                hi_len = hi_len + 8'd1;
            end else if (in_bus) begin
                in_bus = 1'b0;
                check_ev(ev(K_BUS, m_bc1, m_dout, hi_len, m_addr, m_rel, 3'd0));
            end
            if (done) check_ev(ev(K_DONE, 1'b0, 8'h00, 8'd0, cmd_addr, 12'(cyc - t0 + 1), 3'd0));
        end
    end

    // ---------------- drivers ----------------
    task automatic rom_clear();
        for (int i = 0; i < 4096; i++) rom[i] = 10'h300;
    endtask

    task automatic start_play(input logic [11:0] a, input logic with_stop);
        @(posedge clk);
        #1;
        start_addr = a;
        start = 1'b1;
        stop  = with_stop;
        @(posedge clk);  // edge 0
        #1;
        start = 1'b0;
        stop  = 1'b0;
        t0    = cyc;
    endtask

    // Returns #1 after edge n (relative to the start edge).
    task automatic wait_rel(input int n);
        while (cyc - t0 < n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_stop_at(input int n);
        wait_rel(n - 1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        while ((exp_q.size() != 0) && (n < max_cyc)) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout got pending=%0d exp pending=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic push_basic();
        exp_q.push_back(ev(K_BUS,  1'b1, 8'h07, 8'd8, 12'h000, 12'd3,  3'd0));
        exp_q.push_back(ev(K_BUS,  1'b0, 8'h38, 8'd8, 12'h001, 12'd16, 3'd0));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'h002, 12'd29, 3'd0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        start_addr = '0;
        rom_clear();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {10'd0, cmd_addr, bdir, bc1, dout, busy, done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: latch 07, write 38, end; start+stop together; start while busy ignored
        rom_clear();
        rom[0] = 10'h107; rom[1] = 10'h038; rom[2] = 10'h300;
        push_basic();
        start_play(12'h000, 1'b1);
        wait_rel(19);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(200, "basic");
        @(negedge clk);
        chk("basic_busy_after", {31'd0, busy}, 32'd0);

        // 2: wait 256 cen ticks with cen toggling each clk
        rom_clear();
        rom[0] = 10'h201; rom[1] = 10'h100; rom[2] = 10'h300;
        exp_q.push_back(ev(K_BUS,  1'b1, 8'h00, 8'd8, 12'h001, 12'd519, 3'd2));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'h002, 12'd531, 3'd2));
        cen_run = 1'b1;
        start_play(12'h000, 1'b0);
        wait_rel(400);
        chk("wait_busy_mid", {31'd0, busy}, 32'd1);
        drain(800, "wait");
        cen_run = 1'b0;

        // 3: stop during BUS of a data write
        rom_clear();
        rom[0] = 10'h038; rom[1] = 10'h155; rom[2] = 10'h300;
        exp_q.push_back(ev(K_BUS,  1'b0, 8'h38, 8'd8, 12'h000, 12'd3,  3'd0));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'h000, 12'd13, 3'd0));
        start_play(12'h000, 1'b0);
        pulse_stop_at(5);
        drain(200, "stop");
        @(negedge clk);
        chk("stop_busy_after", {31'd0, busy}, 32'd0);

        // 4: last ROM address is a write with no end
        rom_clear();
        rom[4095] = 10'h0AA;
        exp_q.push_back(ev(K_BUS,  1'b0, 8'hAA, 8'd8, 12'hFFF, 12'd3,  3'd0));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'hFFF, 12'd14, 3'd0));
        start_play(12'hFFF, 1'b0);
        drain(200, "exhaust");
        @(negedge clk);
        chk("exhaust_addr_busy", {19'd0, cmd_addr, busy}, {19'd0, 12'hFFF, 1'b0});

        // 5: reset mid-BUS, then replay
        rom_clear();
        rom[0] = 10'h107; rom[1] = 10'h038; rom[2] = 10'h300;
        start_play(12'h000, 1'b0);
        wait_rel(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_pins", {21'd0, bdir, bc1, dout, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_bus_addr", {20'd0, cmd_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        push_basic();
        start_play(12'h000, 1'b0);
        drain(200, "replay");

        // 6: ROM {latch 00, end}
        rom_clear();
        rom[0] = 10'h100; rom[1] = 10'h300;
`ifdef JT49_PLAYER_LOOP_EN
        exp_q.push_back(ev(K_BUS,  1'b1, 8'h00, 8'd8, 12'h000, 12'd3,  3'd0));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'h001, 12'd16, 3'd0));
        exp_q.push_back(ev(K_BUS,  1'b1, 8'h00, 8'd8, 12'h000, 12'd19, 3'd0));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'h001, 12'd32, 3'd0));
        exp_q.push_back(ev(K_BUS,  1'b1, 8'h00, 8'd8, 12'h000, 12'd35, 3'd0));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'h000, 12'd45, 3'd0));
        start_play(12'h000, 1'b0);
        wait_rel(16);
        chk("loop_busy_after_done", {31'd0, busy}, 32'd1);
        pulse_stop_at(37);
        drain(200, "loop");
`else
        exp_q.push_back(ev(K_BUS,  1'b1, 8'h00, 8'd8, 12'h000, 12'd3,  3'd0));
        exp_q.push_back(ev(K_DONE, 1'b0, 8'h00, 8'd0, 12'h001, 12'd16, 3'd0));
        start_play(12'h000, 1'b0);
        drain(200, "end_only");
`endif
        @(negedge clk);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jt49_cmd_player.md
Name: jt49_cmd_player

Overview:
- Synthesizable register-write sequencer for jt49_bus.
- Fetches 10-bit commands from a synchronous command ROM and drives the PSG bus pins (bdir, bc1, din): address latch, data write, timed wait, end.
- Sits between a boot/demo ROM and jt49_bus. Replaces host-CPU register traffic in standalone builds and in the comparison bench.

Parameters:
- ADDR_W, 12, command ROM address width (4096 entries).
- BUS_CYC, 8, clk cycles bdir is held high per bus operation (min 1).
- GAP_CYC, 2, clk cycles bdir/bc1 are held low after each bus operation (min 1).
- WAIT_SH, 8, wait command length = arg << WAIT_SH cen ticks.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cen  in  1  clock enable; used only as the wait-counter tick.
- start  in  1  begin playback at start_addr; sampled in IDLE only.
- stop  in  1  request early termination.
- start_addr  in  ADDR_W  first command address; latched on accepted start.
- cmd_addr  out  ADDR_W  ROM address.
- cmd_data  in  10  ROM data, valid one clk after cmd_addr changes.
- bdir  out  1  to jt49_bus bdir.
- bc1  out  1  to jt49_bus bc1.
- dout  out  8  to jt49_bus din.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-clk pulse on completion or stop.

Behaviour:
- Reset (async, rst_n=0): state IDLE; bdir=0, bc1=0, dout=0, cmd_addr=0, busy=0, done=0; counters cleared.
- Reset mid-operation aborts immediately; the bus pins drop combinationally-free on the next register update (asynchronous clear).
- Command encoding (cmd_data[9:8]):
  - 00: data write. bdir=1, bc1=0, dout=cmd[7:0].
  - 01: address latch. bdir=1, bc1=1, dout=cmd[7:0].
  - 10: wait (cmd[7:0] << WAIT_SH) cen ticks. Arg 0 means no wait.
  - 11: end.
- States:
  - IDLE: on start, cmd_addr<=start_addr, go to FETCH.
  - FETCH: one cycle for ROM latency, then EXEC.
  - EXEC: decode cmd_data.
    - 0x: register bdir/bc1/dout, load timer with BUS_CYC, go to BUS.
    - 10 with nonzero arg: load wait counter, go to WAIT.
    - 10 with zero arg: go to NEXT.
    - 11: go to FIN.
  - BUS: hold outputs; when timer expires, bdir=0, bc1=0 (dout held), load GAP_CYC, go to GAP.
  - GAP: when timer expires, go to NEXT.
  - WAIT: decrement on cen=1 only; at 0, go to NEXT.
  - NEXT: if cmd_addr == all-ones, go to FIN (no wrap). Otherwise cmd_addr+1, go to FETCH.
  - FIN: done=1 for one clk, go to IDLE.
- Latency: start sampled at edge 0 gives bdir=1 from edge 3.
- Per bus command period: BUS_CYC+GAP_CYC+3 clks.
- Wait counter width is 8+WAIT_SH bits and must not overflow.
- stop:
  - Honoured in FETCH, EXEC, WAIT, GAP and NEXT: go to FIN next cycle.
  - In BUS, the operation completes through GAP first (no truncated bus write), then FIN.
  - Ignored in IDLE.
- start while busy: ignored. start and stop both high in IDLE: start wins, stop ignored.
- bdir and bc1 are never high in any state except BUS.

Optional Feature:
- Macro: JT49_PLAYER_LOOP_EN.
- Defined: an end command (11) pulses done and returns to FETCH at the latched start_addr instead of IDLE. busy stays 1. Only stop, or address exhaustion, reaches IDLE.
- Undefined: end command finishes playback as described above.

Decomposition:
- Package jt49_player_pkg holds:
  - opcode constants (OP_WR=2'b00, OP_ADR=2'b01, OP_WAIT=2'b10, OP_END=2'b11);
  - state enum (IDLE, FETCH, EXEC, BUS, GAP, WAIT, NEXT, FIN).
- Sub-module jt49_player_timer: loadable down-counter with optional tick enable, plus zero flag. Shared by BUS/GAP (tick=1) and WAIT (tick=cen).

Test Plan:
- ROM {1_07, 0_38, 3_00}, start_addr=0, start pulse:
  - bdir=1, bc1=1, dout=07 from edge 3 for 8 clks;
  - 2-clk gap;
  - bdir=1, bc1=0, dout=38 for 8 clks;
  - done pulse; busy=0.
- ROM {2_01, 1_00, 3_00} with cen toggling every clk:
  - bdir first rises ≈ 512 clks (256 cen ticks) after start, ±4 clks.
- stop asserted during the BUS phase of a data write:
  - bdir stays high the full 8 clks, then low;
  - done pulses after GAP; no further commands fetched.
- Last command at address 0xFFF is a write with no end:
  - write completes, then done, cmd_addr stays 0xFFF, state IDLE.
- rst_n pulled low mid-BUS:
  - bdir, bc1, dout, busy all 0 immediately;
  - after release, start replays from start_addr.
- JT49_PLAYER_LOOP_EN defined, ROM {1_00, 3_00}, start_addr=0:
  - done pulses every pass, busy stays 1, address latch repeats;
  - stop ends playback with busy=0.
